// File: rtl/sram_axi_bridge_pkg.sv
// Shared FSM encoding and AXI4 constants for the uncached SRAM-bus to AXI4 bridge.
package sram_axi_bridge_pkg;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_RD_ADDR = 6'b000010,
        ST_RD_DATA = 6'b000100,
        ST_WR_REQ  = 6'b001000,
        ST_WR_RESP = 6'b010000,
        ST_DONE    = 6'b100000
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_1     = 3'd0;
    localparam logic [2:0] SIZE_2     = 3'd1;
    localparam logic [2:0] SIZE_4     = 3'd2;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic logic [2:0] size_from_strb(input logic [3:0] strb);
        logic [2:0] size;
        // Irregular strobe patterns fall back to a full-word transfer.
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_1;
            4'b0011, 4'b1100:                   size = SIZE_2;
            default:                            size = SIZE_4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Single-beat AXI4 bus between the bridge (master) and the interconnect (slave).
interface sram_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_bridge.sv
// Turns one uncached SRAM-style request into a single-beat AXI4 read or write and
// answers with a one-cycle reload pulse. Only one transaction is ever in flight.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_en,
    input  logic [3:0]        req_wsel,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              reload,
    output logic [31:0]       rdata,
    output logic              resp_err,
    sram_axi_bridge_if.master axi
);

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        aw_pend;
    logic        w_pend;
    logic        aw_done;
    logic        w_done;
    logic        unused_rlast;

    assign aw_done      = !aw_pend || axi.awready;
    assign w_done       = !w_pend  || axi.wready;
    assign unused_rlast = axi.rlast;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (req_en) state_nx = (req_wsel == 4'd0) ? ST_RD_ADDR : ST_WR_REQ;
            ST_RD_ADDR: if (axi.arready) state_nx = ST_RD_DATA;
            ST_RD_DATA: if (axi.rvalid) state_nx = ST_DONE;
            ST_WR_REQ:  if (aw_done && w_done) state_nx = ST_WR_RESP;
            ST_WR_RESP: if (axi.bvalid) state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_en) begin
                addr_q <= req_addr;
                if (req_wsel != 4'd0) begin
                    wdata_q <= req_wdata;
                    strb_q  <= req_wsel;
                    aw_pend <= 1'b1;
                    w_pend  <= 1'b1;
                end
            end
            // AW and W retire independently; the FSM leaves WR_REQ once both have.
            if (state == ST_WR_REQ) begin
                if (axi.awready) aw_pend <= 1'b0;
                if (axi.wready)  w_pend  <= 1'b0;
            end
            if (state == ST_RD_DATA && axi.rvalid) begin
                rdata_q <= axi.rdata;
                err_q   <= (axi.rresp != RESP_OKAY);
            end
            if (state == ST_WR_RESP && axi.bvalid) begin
                err_q <= (axi.bresp != RESP_OKAY);
            end
        end
    end

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = {addr_q[31:2], 2'b00};
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = SIZE_4;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = (state == ST_RD_ADDR);
    assign axi.rready  = (state == ST_RD_DATA);

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = size_from_strb(strb_q);
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = aw_pend;

    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = strb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = w_pend;
    assign axi.bready  = (state == ST_WR_RESP);

    assign reload   = (state == ST_DONE);
    assign resp_err = (state == ST_DONE) && err_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Randomized scoreboard bench for sram_axi_bridge: requester, stalling AXI slave,
// and a reload monitor checking against a transaction-level model.
module tb_sram_axi_bridge;

    localparam int CH_AR = 0, CH_R = 1, CH_AW = 2, CH_W = 3, CH_B = 4;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rd_data;
        logic [1:0]  resp;
        int          issue_cyc;
        bit          timed;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_en = 1'b0;
    logic [3:0]  req_wsel = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        reload;
    logic [31:0] rdata;
    logic        resp_err;

    sram_axi_bridge_if axi ();

    sram_axi_bridge #(.AXI_ID(4'd1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_en   (req_en),
        .req_wsel (req_wsel),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .reload   (reload),
        .rdata    (rdata),
        .resp_err (resp_err),
        .axi      (axi)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int stall_lo[5], stall_hi[5];
    bit r_hold = 1'b0;
    bit cur_aw_done = 1'b0, cur_w_done = 1'b0;
    int aw_rise_cyc = 0, w_rise_cyc = 0;
    int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int exp_ar = 0, exp_wr = 0, exp_rd_done = 0, exp_done = 0, n_done = 0;
    logic [31:0] model_rdata = '0;
    txn_t ar_q[$], r_q[$], aw_q[$], w_q[$], b_q[$], exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int stall(input int ch);
        return int'($urandom_range(stall_hi[ch], stall_lo[ch]));
    endfunction

    // Transfer size implied by how many bytes are enabled and whether they form a half.
    function automatic logic [2:0] exp_awsize(input logic [3:0] s);
        case ($countones(s))
            1:       return 3'd0;
            2:       return (s == 4'b0011 || s == 4'b1100) ? 3'd1 : 3'd2;
            default: return 3'd2;
        endcase
    endfunction

    task automatic set_stalls(input int lo, input int hi);
        for (int c = 0; c < 5; c++) begin
            stall_lo[c] = lo;
            stall_hi[c] = hi;
        end
    endtask

    // ---------------- AXI slave: one process per channel ----------------
    initial begin
        int wait_n;
        txn_t t;
        wait_n = -1;
        axi.arready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.arready = 1'b0;
                wait_n = -1;
            end else if (axi.arready) begin
                axi.arready = 1'b0;
                ar_hs++;
                check("arvalid_drop", axi.arvalid, 0);
            end else if (axi.arvalid) begin
                if (wait_n < 0) wait_n = stall(CH_AR);
                if (wait_n == 0) begin
                    wait_n = -1;
                    axi.arready = 1'b1;
                    check("ar_pending", ar_q.size(), 1);
                    if (ar_q.size() != 0) begin
                        t = ar_q.pop_front();
                        check("ar_fields",
                              {axi.araddr, axi.arid, axi.arlen, axi.arsize, axi.arburst},
                              {t.addr & 32'hFFFF_FFFC, 4'd1, 8'd0, 3'd2, 2'b01});
                        r_q.push_back(t);
                    end
                end else begin
                    wait_n--;
                end
            end
        end
    end

    initial begin
        int wait_n;
        txn_t t;
        wait_n = -1;
        axi.rvalid = 1'b0;
        axi.rdata  = '0;
        axi.rresp  = '0;
        axi.rlast  = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.rvalid = 1'b0;
                wait_n = -1;
            end else if (axi.rvalid) begin
                axi.rvalid = 1'b0;
                axi.rdata  = $urandom;
                axi.rresp  = 2'($urandom);
                r_hs++;
            end else if (axi.rready && !r_hold && r_q.size() != 0) begin
                if (wait_n < 0) wait_n = stall(CH_R);
                if (wait_n == 0) begin
                    wait_n = -1;
                    t = r_q.pop_front();
                    axi.rdata  = t.rd_data;
                    axi.rresp  = t.resp;
                    axi.rvalid = 1'b1;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    initial begin
        int wait_n;
        txn_t t;
        wait_n = -1;
        axi.awready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.awready = 1'b0;
                wait_n = -1;
            end else if (axi.awready) begin
                axi.awready = 1'b0;
                aw_hs++;
                check("awvalid_drop", axi.awvalid, 0);
            end else if (axi.awvalid) begin
                if (wait_n < 0) wait_n = stall(CH_AW);
                if (wait_n == 0) begin
                    wait_n = -1;
                    axi.awready = 1'b1;
                    cur_aw_done = 1'b1;
                    aw_rise_cyc = cyc;
                    check("aw_pending", aw_q.size(), 1);
                    if (aw_q.size() != 0) begin
                        t = aw_q.pop_front();
                        check("aw_fields",
                              {axi.awaddr, axi.awid, axi.awlen, axi.awsize, axi.awburst},
                              {t.addr, 4'd1, 8'd0, exp_awsize(t.strb), 2'b01});
                    end
                end else begin
                    wait_n--;
                end
            end
        end
    end

    initial begin
        int wait_n;
        txn_t t;
        wait_n = -1;
        axi.wready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.wready = 1'b0;
                wait_n = -1;
            end else if (axi.wready) begin
                axi.wready = 1'b0;
                w_hs++;
                check("wvalid_drop", axi.wvalid, 0);
            end else if (axi.wvalid) begin
                if (wait_n < 0) wait_n = stall(CH_W);
                if (wait_n == 0) begin
                    wait_n = -1;
                    axi.wready = 1'b1;
                    cur_w_done = 1'b1;
                    w_rise_cyc = cyc;
                    check("w_pending", w_q.size(), 1);
                    if (w_q.size() != 0) begin
                        t = w_q.pop_front();
                        check("w_fields", {axi.wdata, axi.wstrb, axi.wlast}, {t.wdata, t.strb, 1'b1});
                    end
                end else begin
                    wait_n--;
                end
            end
        end
    end

    initial begin
        int wait_n;
        txn_t t;
        wait_n = -1;
        axi.bvalid = 1'b0;
        axi.bresp  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.bvalid = 1'b0;
                wait_n = -1;
            end else if (axi.bvalid) begin
                axi.bvalid = 1'b0;
                axi.bresp  = 2'($urandom);
                b_hs++;
            end else if (axi.bready && b_q.size() != 0) begin
                if (wait_n < 0) wait_n = stall(CH_B);
                if (wait_n == 0) begin
                    wait_n = -1;
                    check("b_after_aw_w", {cur_aw_done, cur_w_done}, 2'b11);
                    t = b_q.pop_front();
                    axi.bresp  = t.resp;
                    axi.bvalid = 1'b1;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    // ---------------- Completion monitor / scoreboard ----------------
    initial begin
        bit   prev;
        txn_t t;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
                model_rdata = '0;
            end else begin
                if (reload) begin
                    check("reload_width", prev, 0);
                    check("reload_expected", exp_q.size(), 1);
                    if (exp_q.size() != 0) begin
                        t = exp_q.pop_front();
                        if (!t.is_wr) model_rdata = t.rd_data;
                        check("reload_rdata", rdata, model_rdata);
                        check("reload_resp_err", resp_err, t.resp != 2'b00);
                        if (t.timed) check("latency", cyc - t.issue_cyc, 3);
                        n_done++;
                    end
                end else begin
                    check("rdata_hold", rdata, model_rdata);
                    check("idle_resp_err", resp_err, 0);
                end
                prev = reload;
            end
        end
    end

    // ---------------- Requester ----------------
    task automatic do_req(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] rd, input logic [1:0] resp);
        txn_t t;
        bit   seen;
        t.is_wr   = is_wr;
        t.addr    = addr;
        t.wdata   = wdata;
        t.strb    = strb;
        t.rd_data = rd;
        t.resp    = resp;
        t.timed   = 1'b1;
        for (int c = 0; c < 5; c++) if (stall_hi[c] != 0) t.timed = 1'b0;
        @(negedge clk);
        t.issue_cyc = cyc;
        if (is_wr) begin
            cur_aw_done = 1'b0;
            cur_w_done  = 1'b0;
            aw_q.push_back(t);
            w_q.push_back(t);
            b_q.push_back(t);
            exp_wr++;
        end else begin
            ar_q.push_back(t);
            exp_ar++;
            exp_rd_done++;
        end
        exp_q.push_back(t);
        exp_done++;
        req_en    = 1'b1;
        req_wsel  = is_wr ? strb : 4'd0;
        req_addr  = addr;
        req_wdata = wdata;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            // Address and data are latched at acceptance; scrambling them must not matter.
            req_addr  = $urandom;
            req_wdata = $urandom;
            seen = reload;
        end
        if (!seen) check("reload_timeout", seen, 1);
        req_en = 1'b0;
    endtask

    initial begin
        bit          wr;
        bit          seen;
        logic [3:0]  s;
        logic [1:0]  rsp;
        txn_t        t;

        set_stalls(0, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {reload, resp_err, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 7'd0);
        check("reset_rdata", rdata, 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait read and byte write
        do_req(1'b0, 32'h1FAF_F202, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00);
        do_req(1'b1, 32'hBFD0_0002, 32'h00AB_0000, 4'b0100, 32'h0, 2'b00);

        // W accepted three cycles ahead of AW
        stall_lo[CH_AW] = 3;
        stall_hi[CH_AW] = 3;
        do_req(1'b1, 32'h1000_0004, 32'h1234_5678, 4'b1111, 32'h0, 2'b00);
        check("w_before_aw_gap", aw_rise_cyc - w_rise_cyc, 3);
        set_stalls(0, 0);

        // Slave error after a five-cycle stall, then back-to-back write and read
        stall_lo[CH_R] = 5;
        stall_hi[CH_R] = 5;
        do_req(1'b0, 32'h2000_0010, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10);
        set_stalls(0, 0);
        do_req(1'b1, 32'h3000_0020, 32'hA5A5_5A5A, 4'b0011, 32'h0, 2'b00);
        do_req(1'b0, 32'h3000_0020, 32'h0, 4'h0, 32'h0F0F_1E1E, 2'b00);

        // Randomized mix with random channel stalls and occasional error responses
        for (int n = 0; n < 150; n++) begin
            for (int c = 0; c < 5; c++) begin
                stall_lo[c] = 0;
                stall_hi[c] = int'($urandom_range(3, 0));
            end
            wr  = 1'($urandom_range(1, 0));
            s   = 4'($urandom_range(15, 1));
            rsp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            do_req(wr, $urandom, $urandom, s, $urandom, rsp);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        set_stalls(0, 0);

        // Asynchronous reset while waiting in RD_DATA, then a clean read
        r_hold = 1'b1;
        t.is_wr = 1'b0;
        t.addr  = 32'h4000_0008;
        t.wdata = '0;
        t.strb  = '0;
        t.rd_data = 32'h7777_8888;
        t.resp  = 2'b00;
        t.issue_cyc = 0;
        t.timed = 1'b0;
        @(negedge clk);
        ar_q.push_back(t);
        exp_ar++;
        req_en   = 1'b1;
        req_wsel = 4'd0;
        req_addr = t.addr;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = axi.rready;
        end
        check("reach_rd_data", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {reload, resp_err, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 7'd0);
        check("async_reset_rdata", rdata, 32'd0);
        req_en = 1'b0;
        repeat (2) @(negedge clk);
        r_q.delete();
        r_hold = 1'b0;
        #2 rst_n = 1'b1;
        do_req(1'b0, 32'h5000_000C, 32'h0, 4'h0, 32'h1357_9BDF, 2'b00);
        repeat (3) @(negedge clk);

        check("ar_handshakes", ar_hs, exp_ar);
        check("r_handshakes", r_hs, exp_rd_done);
        check("aw_handshakes", aw_hs, exp_wr);
        check("w_handshakes", w_hs, exp_wr);
        check("b_handshakes", b_hs, exp_wr);
        check("completions", n_done, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
